axi_rd_arbiter: RTL

- Arbitrates the single AXI3 read channel (AR/R) of the CPU top between two requesters: instruction fetch (port 0) and data load (port 1).
- Sits between the cache/uncached-access logic and the top-level AXI ports (arid…rready).
- One outstanding read burst at a time; R beats are routed back to the granted requester.
- Write channels are out of scope (separate block).

---
 rtl/axi_rd_arb_pkg.sv | 17 +
 rtl/axi_rd_arb_pick.sv | 32 +++
 rtl/axi_rd_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared encodings for the AXI3 read-channel arbiter.
// FSM state encoding, fixed AXI field values and requester indices.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int REQ_INST = 0;
  localparam int REQ_DATA = 1;

endpackage

// File: rtl/axi_rd_arb_pick.sv
// axi_rd_arb_pick: combinational winner select, one-hot grant.
// Build option AXI_RD_ARB_RR_EN: round-robin tie break using ptr,
// otherwise data load always beats instruction fetch.
module axi_rd_arb_pick
  import axi_rd_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
`ifdef AXI_RD_ARB_RR_EN
  input  logic       ptr,
`endif
  output logic [1:0] gnt
);

  // Pick at most one requester; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
`ifdef AXI_RD_ARB_RR_EN
    if (inst_req && data_req) begin
      gnt[REQ_DATA] = ptr;
      gnt[REQ_INST] = ~ptr;
    end else begin
      gnt[REQ_INST] = inst_req;
      gnt[REQ_DATA] = data_req;
    end
`else
    gnt[REQ_DATA] = data_req;
    gnt[REQ_INST] = inst_req & ~data_req;
`endif
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI3 AR/R channel between instruction fetch
// (requester 0) and data load (requester 1), one burst in flight at a time.
// Build option AXI_RD_ARB_RR_EN selects round-robin instead of data-first.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [3:0]        inst_len,
  input  logic [2:0]        inst_size,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic              inst_rlast,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_len,
  input  logic [2:0]        data_size,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic              data_rlast,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  state_t     state;
  logic       win_data;
  logic [3:0] beat_cnt;
  logic [1:0] pick_gnt;
  logic       ar_hs;
  logic       beat;

  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // Handshakes are masked during reset so nothing leaks to the requesters.
  assign ar_hs = arvalid & arready & ~reset;
  assign beat  = rvalid & rready & ~reset;

`ifdef AXI_RD_ARB_RR_EN
  logic rr_ptr;

  // Hand the tie-break to the requester that just lost.
  always_ff @(posedge aclk) begin
    if (reset)
      rr_ptr <= 1'b0;
    else if (ar_hs)
      rr_ptr <= ~win_data;
  end

  axi_rd_arb_pick u_pick (
    .inst_req (inst_req),
    .data_req (data_req),
    .ptr      (rr_ptr),
    .gnt      (pick_gnt)
  );
`else
  axi_rd_arb_pick u_pick (
    .inst_req (inst_req),
    .data_req (data_req),
    .gnt      (pick_gnt)
  );
`endif

  // IDLE -> AR -> R -> IDLE; AR fields are latched once and held until handshake.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      arid     <= 4'd0;
      araddr   <= '0;
      arlen    <= 4'd0;
      arsize   <= 3'd0;
      arburst  <= 2'b00;
      win_data <= 1'b0;
      beat_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_gnt != 2'b00) begin
            win_data <= pick_gnt[REQ_DATA];
            arid     <= pick_gnt[REQ_DATA] ? ID_DATA   : ID_INST;
            araddr   <= pick_gnt[REQ_DATA] ? data_addr : inst_addr;
            arlen    <= pick_gnt[REQ_DATA] ? data_len  : inst_len;
            arsize   <= pick_gnt[REQ_DATA] ? data_size : inst_size;
            arburst  <= BURST_INCR;
            arvalid  <= 1'b1;
            state    <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            beat_cnt <= 4'd0;
            state    <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (rlast) begin
              rready <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
        default: begin
          arvalid <= 1'b0;
          rready  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Route grant pulses and R beats to whichever requester won arbitration.
  always_comb begin
    inst_gnt    = ar_hs & ~win_data;
    data_gnt    = ar_hs & win_data;
    inst_rvalid = beat & ~win_data;
    data_rvalid = beat & win_data;
    inst_rlast  = beat & ~win_data & rlast;
    data_rlast  = beat & win_data & rlast;
    rd_data     = beat ? rdata : '0;
    rd_err      = beat & ((rresp != RESP_OKAY) ||
                          (rlast && (beat_cnt != arlen)) ||
                          ((beat_cnt == arlen) && !rlast) ||
                          (rid != arid));
  end

endmodule
